// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe controller slice.
//   - cell codes for the 2-bit board cells
//   - controller state enum
//   - board size constant
//   - helper to hand the turn to the other player
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_X     = 2'b01;
   localparam logic [1:0] CELL_O     = 2'b10;

   localparam int BOARD_SIZE = 9;

   typedef enum logic [1:0] {
      StIdle,
      StPlay,
      StCheck,
      StDone
   } state_e;

   function automatic logic [1:0] other_player(input logic [1:0] p);
      return (p == CELL_X) ? CELL_O : CELL_X;
   endfunction

endpackage

// File: rtl/turn_timer.sv
// turn_timer: loadable down-counter that flags the end of a turn.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reload the count (turn starts afresh)
//   en         : count this cycle
//   expired    : high in the TIMEOUT-th enabled cycle after a reload;
//                the counter reloads itself on that cycle
module turn_timer #(
   parameter int unsigned TIMEOUT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q;

   assign expired = en && !clr && (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= LOAD;
      end else if (clr) begin
         cnt_q <= LOAD;
      end else if (en) begin
         if (cnt_q == '0) cnt_q <= LOAD;
         else             cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/winner_detector.sv
// winner_detector: combinational three-in-a-row detector.
//   pos1..pos9 : cell codes, row-major
//   win        : some row, column or diagonal holds three equal non-empty cells
//   who        : code of that player (00 when no win)
module winner_detector
   import ttt_pkg::*;
(
   input  logic [1:0] pos1,
   input  logic [1:0] pos2,
   input  logic [1:0] pos3,
   input  logic [1:0] pos4,
   input  logic [1:0] pos5,
   input  logic [1:0] pos6,
   input  logic [1:0] pos7,
   input  logic [1:0] pos8,
   input  logic [1:0] pos9,
   output logic       win,
   output logic [1:0] who
);

   function automatic logic line3(input logic [1:0] a, input logic [1:0] b,
                                  input logic [1:0] c);
      return (a != CELL_EMPTY) && (a == b) && (b == c);
   endfunction

   always_comb begin
      win = 1'b1;
      who = CELL_EMPTY;
      if      (line3(pos1, pos2, pos3)) who = pos1;
      else if (line3(pos4, pos5, pos6)) who = pos4;
      else if (line3(pos7, pos8, pos9)) who = pos7;
      else if (line3(pos1, pos4, pos7)) who = pos1;
      else if (line3(pos2, pos5, pos8)) who = pos2;
      else if (line3(pos3, pos6, pos9)) who = pos3;
      else if (line3(pos1, pos5, pos9)) who = pos1;
      else if (line3(pos3, pos5, pos7)) who = pos3;
      else                              win = 1'b0;
   end

endmodule

// File: rtl/board_controller.sv
// board_controller: owns the nine-cell board, validates and applies moves,
// alternates turns and decides win/draw using winner_detector's result.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, restart      : begin a game from IDLE / abort to IDLE
//   move_valid, move_pos: move request, cell 1..9 row-major
//   win, who            : from winner_detector, sampled only in CHECK
//   pos1..pos9          : board cells
//   player              : side to move
//   move_ready          : high in PLAY
//   move_err, timeout   : one-cycle pulses (rejected move / forfeited turn)
//   game_over, draw     : DONE, and DONE without a winner
//   winner              : winning code held in DONE
//   move_count          : cells filled
module board_controller
   import ttt_pkg::*;
#(
   parameter logic [1:0]  FIRST_PLAYER = CELL_X,
   parameter int unsigned TURN_TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       restart,
   input  logic       move_valid,
   input  logic [3:0] move_pos,
   input  logic       win,
   input  logic [1:0] who,
   output logic [1:0] pos1,
   output logic [1:0] pos2,
   output logic [1:0] pos3,
   output logic [1:0] pos4,
   output logic [1:0] pos5,
   output logic [1:0] pos6,
   output logic [1:0] pos7,
   output logic [1:0] pos8,
   output logic [1:0] pos9,
   output logic [1:0] player,
   output logic       move_ready,
   output logic       move_err,
   output logic       timeout,
   output logic       game_over,
   output logic       draw,
   output logic [1:0] winner,
   output logic [3:0] move_count
);

   logic [1:0] cells_q [BOARD_SIZE];
   state_e     state_q;
   logic [1:0] player_q;
   logic [1:0] winner_q;
   logic       move_ready_q;
   logic       move_err_q;
   logic       timeout_q;
   logic       game_over_q;
   logic       draw_q;
   logic [3:0] move_count_q;

   logic       pos_ok;
   logic [3:0] idx;
   logic       cell_free;
   logic       accept;
   logic       timer_expired;

   always_comb begin
      pos_ok    = (move_pos >= 4'd1) && (move_pos <= 4'(BOARD_SIZE));
      idx       = move_pos - 4'd1;
      cell_free = 1'b0;
      if (pos_ok) cell_free = (cells_q[idx] == CELL_EMPTY);
      accept    = (state_q == StPlay) && move_valid && cell_free;
   end

   // The timer runs only while waiting for a move; any other state reloads it,
   // so every entry into PLAY starts a full turn.
   if (TURN_TIMEOUT > 0) begin : g_timer
      turn_timer #(
         .TIMEOUT (TURN_TIMEOUT)
      ) u_turn_timer (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (state_q != StPlay),
         .en      (state_q == StPlay),
         .expired (timer_expired)
      );
   end else begin : g_no_timer
      assign timer_expired = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BOARD_SIZE; i++) cells_q[i] <= CELL_EMPTY;
         state_q      <= StIdle;
         player_q     <= FIRST_PLAYER;
         winner_q     <= CELL_EMPTY;
         move_ready_q <= 1'b0;
         move_err_q   <= 1'b0;
         timeout_q    <= 1'b0;
         game_over_q  <= 1'b0;
         draw_q       <= 1'b0;
         move_count_q <= 4'd0;
      end else begin
         move_err_q <= 1'b0;
         timeout_q  <= 1'b0;
         if (restart) begin
            for (int i = 0; i < BOARD_SIZE; i++) cells_q[i] <= CELL_EMPTY;
            state_q      <= StIdle;
            winner_q     <= CELL_EMPTY;
            move_ready_q <= 1'b0;
            game_over_q  <= 1'b0;
            draw_q       <= 1'b0;
            move_count_q <= 4'd0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start) begin
                     state_q      <= StPlay;
                     player_q     <= FIRST_PLAYER;
                     move_count_q <= 4'd0;
                     move_ready_q <= 1'b1;
                  end
               end
               StPlay: begin
                  if (accept) begin
                     // An accepted move wins over a timer expiring this cycle.
                     cells_q[idx] <= player_q;
                     move_count_q <= move_count_q + 4'd1;
                     state_q      <= StCheck;
                     move_ready_q <= 1'b0;
                  end else begin
                     if (move_valid) move_err_q <= 1'b1;
                     if (timer_expired) begin
                        timeout_q <= 1'b1;
                        player_q  <= other_player(player_q);
                     end
                  end
               end
               StCheck: begin
                  if (win) begin
                     winner_q    <= who;
                     state_q     <= StDone;
                     game_over_q <= 1'b1;
                  end else if (move_count_q == 4'(BOARD_SIZE)) begin
                     draw_q      <= 1'b1;
                     state_q     <= StDone;
                     game_over_q <= 1'b1;
                  end else begin
                     player_q     <= other_player(player_q);
                     state_q      <= StPlay;
                     move_ready_q <= 1'b1;
                  end
               end
               StDone: begin
                  // Board frozen until restart or reset.
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign pos1       = cells_q[0];
   assign pos2       = cells_q[1];
   assign pos3       = cells_q[2];
   assign pos4       = cells_q[3];
   assign pos5       = cells_q[4];
   assign pos6       = cells_q[5];
   assign pos7       = cells_q[6];
   assign pos8       = cells_q[7];
   assign pos9       = cells_q[8];
   assign player     = player_q;
   assign move_ready = move_ready_q;
   assign move_err   = move_err_q;
   assign timeout    = timeout_q;
   assign game_over  = game_over_q;
   assign draw       = draw_q;
   assign winner     = winner_q;
   assign move_count = move_count_q;

endmodule

// File: tb/tb_board_controller.sv
module tb_board_controller;

   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       rst_n, start, restart, move_valid;
   logic [3:0] move_pos;
   logic       win;
   logic [1:0] who;
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   logic [1:0] player, winner;
   logic       move_ready, move_err, timeout, game_over, draw;
   logic [3:0] move_count;

   int total = 0;
   int bad   = 0;

   // Reference model: game rules in plain integers (0 idle, 1 play, 2 check, 3 done).
   int m_state, m_player, m_err, m_tmo, m_winner, m_draw, m_count, m_timer;
   int m_board[9];

   always #5 clk = ~clk;

   board_controller #(
      .FIRST_PLAYER (2'b01),
      .TURN_TIMEOUT (TMO)
   ) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .restart (restart),
      .move_valid (move_valid), .move_pos (move_pos), .win (win), .who (who),
      .pos1 (pos1), .pos2 (pos2), .pos3 (pos3), .pos4 (pos4), .pos5 (pos5),
      .pos6 (pos6), .pos7 (pos7), .pos8 (pos8), .pos9 (pos9),
      .player (player), .move_ready (move_ready), .move_err (move_err),
      .timeout (timeout), .game_over (game_over), .draw (draw),
      .winner (winner), .move_count (move_count)
   );

   winner_detector u_wd (
      .pos1 (pos1), .pos2 (pos2), .pos3 (pos3), .pos4 (pos4), .pos5 (pos5),
      .pos6 (pos6), .pos7 (pos7), .pos8 (pos8), .pos9 (pos9),
      .win (win), .who (who)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int model_winner();
      int b[9];
      b = m_board;
      for (int r = 0; r < 3; r++)
         if (b[3*r] != 0 && b[3*r] == b[3*r+1] && b[3*r] == b[3*r+2]) return b[3*r];
      for (int c = 0; c < 3; c++)
         if (b[c] != 0 && b[c] == b[c+3] && b[c] == b[c+6]) return b[c];
      if (b[0] != 0 && b[0] == b[4] && b[0] == b[8]) return b[0];
      if (b[2] != 0 && b[2] == b[4] && b[2] == b[6]) return b[2];
      return 0;
   endfunction

   task automatic model_reset();
      m_state = 0; m_player = 1; m_err = 0; m_tmo = 0;
      m_winner = 0; m_draw = 0; m_count = 0; m_timer = 0;
      for (int i = 0; i < 9; i++) m_board[i] = 0;
   endtask

   task automatic model_edge(input logic s, input logic r, input logic v, input int p);
      int w;
      m_err = 0;
      m_tmo = 0;
      if (r) begin
         for (int i = 0; i < 9; i++) m_board[i] = 0;
         m_winner = 0; m_draw = 0; m_count = 0; m_state = 0; m_timer = 0;
      end else begin
         case (m_state)
            0: if (s) begin
               m_state = 1; m_player = 1; m_count = 0; m_timer = 0;
            end
            1: if (v && p >= 1 && p <= 9 && m_board[p-1] == 0) begin
               m_board[p-1] = m_player; m_count++; m_state = 2; m_timer = 0;
            end else begin
               if (v) m_err = 1;
               m_timer++;
               if (m_timer == TMO) begin
                  m_tmo = 1; m_player = 3 - m_player; m_timer = 0;
               end
            end
            2: begin
               w = model_winner();
               if (w != 0) begin
                  m_winner = w; m_state = 3;
               end else if (m_count == 9) begin
                  m_draw = 1; m_state = 3;
               end else begin
                  m_player = 3 - m_player; m_state = 1; m_timer = 0;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_all(input string ctx);
      logic [1:0] b[9];
      b = '{pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
      for (int i = 0; i < 9; i++) chk($sformatf("%s_pos%0d", ctx, i + 1), 8'(b[i]), 8'(m_board[i]));
      chk({ctx, "_player"}, 8'(player), 8'(m_player));
      chk({ctx, "_ready"}, 8'(move_ready), 8'(m_state == 1));
      chk({ctx, "_err"}, 8'(move_err), 8'(m_err));
      chk({ctx, "_timeout"}, 8'(timeout), 8'(m_tmo));
      chk({ctx, "_game_over"}, 8'(game_over), 8'(m_state == 3));
      chk({ctx, "_draw"}, 8'(draw), 8'(m_draw));
      chk({ctx, "_winner"}, 8'(winner), 8'(m_winner));
      chk({ctx, "_count"}, 8'(move_count), 8'(m_count));
   endtask

   task automatic step(input string ctx, input logic s, input logic r, input logic v,
                       input int p);
      start = s; restart = r; move_valid = v; move_pos = 4'(p);
      @(posedge clk);
      #1;
      model_edge(s, r, v, p);
      check_all(ctx);
   endtask

   // A move followed by its CHECK cycle.
   task automatic play(input string ctx, input int p);
      step(ctx, 1'b0, 1'b0, 1'b1, p);
      step(ctx, 1'b0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      int seq_win[5]  = '{1, 4, 2, 5, 3};
      int seq_draw[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};

      rst_n = 1'b0; start = 1'b0; restart = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // X wins along the top row.
      step("xw_start", 1'b1, 1'b0, 1'b0, 0);
      foreach (seq_win[i]) play("xwin", seq_win[i]);
      chk("xwin_game_over_c", 8'(game_over), 8'd1);
      chk("xwin_winner_c", 8'(winner), 8'd1);
      chk("xwin_draw_c", 8'(draw), 8'd0);
      chk("xwin_count_c", 8'(move_count), 8'd5);

      // Moves in DONE are ignored without error.
      step("done_mv", 1'b0, 1'b0, 1'b1, 9);
      step("done_mv", 1'b0, 1'b0, 1'b1, 0);
      chk("done_no_err_c", 8'(move_err), 8'd0);
      chk("done_pos9_c", 8'(pos9), 8'd0);

      // Draw.
      step("dr_restart", 1'b0, 1'b1, 1'b0, 0);
      step("dr_start", 1'b1, 1'b0, 1'b0, 0);
      foreach (seq_draw[i]) play("draw", seq_draw[i]);
      chk("draw_flag_c", 8'(draw), 8'd1);
      chk("draw_winner_c", 8'(winner), 8'd0);
      chk("draw_count_c", 8'(move_count), 8'd9);

      // Illegal moves: repeat cell, position 0, position 10.
      step("il_restart", 1'b0, 1'b1, 1'b0, 0);
      step("il_start", 1'b1, 1'b0, 1'b0, 0);
      play("il", 5);
      step("il_again", 1'b0, 1'b0, 1'b1, 5);
      chk("il_err1_c", 8'(move_err), 8'd1);
      step("il_zero", 1'b0, 1'b0, 1'b1, 0);
      chk("il_err2_c", 8'(move_err), 8'd1);
      step("il_ten", 1'b0, 1'b0, 1'b1, 10);
      chk("il_err3_c", 8'(move_err), 8'd1);
      chk("il_pos5_c", 8'(pos5), 8'd1);
      chk("il_player_c", 8'(player), 8'd2);
      chk("il_count_c", 8'(move_count), 8'd1);
      step("il_idle", 1'b0, 1'b0, 1'b0, 0);
      chk("il_err_clear_c", 8'(move_err), 8'd0);

      // Turn timeout after TMO idle PLAY cycles.
      step("to_restart", 1'b0, 1'b1, 1'b0, 0);
      step("to_start", 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < TMO; i++) step("to_idle", 1'b0, 1'b0, 1'b0, 0);
      chk("to_pulse_c", 8'(timeout), 8'd1);
      chk("to_player_c", 8'(player), 8'd2);
      play("to_move", 1);
      chk("to_pos1_c", 8'(pos1), 8'd2);

      // Restart beats a same-cycle move.
      step("rs_move", 1'b0, 1'b0, 1'b1, 5);
      step("rs_check", 1'b0, 1'b0, 1'b0, 0);
      step("rs_both", 1'b0, 1'b1, 1'b1, 9);
      chk("rs_pos9_c", 8'(pos9), 8'd0);
      chk("rs_ready_c", 8'(move_ready), 8'd0);

      // Async reset mid-cycle while in DONE.
      step("ar_start", 1'b1, 1'b0, 1'b0, 0);
      foreach (seq_win[i]) play("ar", seq_win[i]);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_game_over_c", 8'(game_over), 8'd0);
      #2 rst_n = 1'b1;

      // Randomised games, including idle stretches, restarts and stray starts.
      for (int g = 0; g < 30; g++) begin
         step("rnd_start", 1'b1, 1'b0, 1'b0, 0);
         for (int k = 0; k < 50; k++) begin
            logic r, v, s;
            r = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0) && (g % 5 != 4 || $urandom_range(0, 3) == 0);
            step("rnd", s, r, v, $urandom_range(0, 3) == 0 ? $urandom_range(0, 15)
                                                            : $urandom_range(1, 9));
         end
         step("rnd_restart", 1'b0, 1'b1, 1'b0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_controller.md
# board_controller

Sequential game controller that sits directly upstream of the winner detector. It owns the nine-cell board register, validates and applies player moves, and alternates turns. It drives the nine 2-bit cell values into `winner_detector` and samples that block's `win`/`who` one cycle after each accepted move to decide whether the game is won, drawn or continues.

## Interface
- `FIRST_PLAYER`, default 2'b01: cell code of the player who moves first after `start` (2'b01 = X, 2'b10 = O).
- `TURN_TIMEOUT`, default 0: number of PLAY cycles without an accepted move before the turn is forfeited; 0 disables the timer.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  begin a game from IDLE (one-cycle pulse).
- `restart`  in  1  abort any game, clear the board and return to IDLE.
- `move_valid`  in  1  move request this cycle.
- `move_pos`  in  4  target cell, 1..9, row-major (1 = top-left, 9 = bottom-right).
- `win`  in  1  from winner_detector.
- `who`  in  2  from winner_detector.
- `pos1`..`pos9`  out  2 each  cell contents: 00 empty, 01 X, 10 O.
- `player`  out  2  player whose turn it is.
- `move_ready`  out  1  high only in PLAY.
- `move_err`  out  1  one-cycle pulse on a rejected move.
- `timeout`  out  1  one-cycle pulse on a forfeited turn.
- `game_over`  out  1  high in DONE.
- `draw`  out  1  high in DONE when no winner.
- `winner`  out  2  winning player code, held in DONE; 00 otherwise.
- `move_count`  out  4  number of cells filled, 0..9.

## Operation
- States: IDLE, PLAY, CHECK, DONE.
- IDLE: board empty. `start` moves to PLAY, loads `player` = FIRST_PLAYER and clears `move_count`.
- PLAY: an accepted move requires `move_valid`, `move_pos` in 1..9, and the target cell = 00.
  - Accepted move: write `player` into the target cell, increment `move_count`, go to CHECK.
  - Rejected move (out-of-range position or occupied cell): pulse `move_err`; board, player and state are unchanged.
- CHECK: one cycle, evaluated on the updated board.
  - `win` = 1: latch `winner` = `who` and go to DONE.
  - Otherwise, `move_count` = 9: set `draw` and go to DONE.
  - Otherwise: toggle `player` (01↔10) and return to PLAY.
- DONE: board frozen; `move_valid` is ignored and no `move_err` is raised. Leave only via `restart` or reset.
- Turn timer (only when TURN_TIMEOUT > 0):
  - Counts PLAY cycles and clears on entry to PLAY.
  - On reaching TURN_TIMEOUT with no move accepted: pulse `timeout`, toggle `player`, restart the count, stay in PLAY.
  - A move accepted in the same cycle as expiry takes priority; no timeout is raised.
- `restart` is honoured in every state. It has priority over `start` and `move_valid` in the same cycle. It clears all cells, `winner`, `draw` and `move_count`, and goes to IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all `pos*` = 00, `player` = FIRST_PLAYER, `move_ready` = 0, `move_err` = 0, `timeout` = 0, `game_over` = 0, `draw` = 0, `winner` = 00, `move_count` = 0, state = IDLE.
- Reset asserted mid-game clears the board immediately, without waiting for a clock edge.
- All outputs are registered.
- Move latency for an accept at edge N:
  - Cell visible after edge N.
  - CHECK occupies cycle N+1.
  - `game_over` or the toggled `player` is visible after edge N+1.
- Throughput: at most one move every 2 cycles; `move_ready` is low during CHECK.
- `move_err` and `timeout` are high for exactly one cycle following the offending or expiring edge.
- `win`/`who` are sampled only in CHECK; their values in other states are don't-care.

## Structure
- Shared package `ttt_pkg` holds:
  - Cell codes: `CELL_EMPTY` = 00, `CELL_X` = 01, `CELL_O` = 10.
  - The 2-bit state enum (IDLE/PLAY/CHECK/DONE).
  - Board size constant 9.
- One sub-module, `turn_timer`: a loadable down-counter with `clr`, `en` and an `expired` pulse, parameterised by TURN_TIMEOUT. It is tied off when TURN_TIMEOUT = 0.
- The bench instantiates `board_controller` together with `winner_detector`, closing the loop through `pos1`..`pos9` and `win`/`who`.

## Test plan
- X win, top row: `start`, then moves 1,4,2,5,3 → after the CHECK for cell 3, `game_over` = 1, `winner` = 01, `draw` = 0, `move_count` = 5.
- Draw: moves 1,2,3,5,4,6,8,7,9 → `game_over` = 1, `draw` = 1, `winner` = 00, `move_count` = 9.
- Illegal moves: play cell 5, then on the next ready cycle play 5 again, then `move_pos` = 0, then 10 → three `move_err` pulses; `pos5` = 01, `player` = 10, `move_count` = 1.
- Timeout (TURN_TIMEOUT = 8): after `start`, idle for 8 cycles → one `timeout` pulse, `player` = 10, board still empty; then a move at cell 1 writes `pos1` = 10.
- Restart and reset: `restart` asserted together with `move_valid` mid-game → board all 00, state IDLE, no cell written. Async `rst_n` pulse between clock edges in DONE → all outputs at their reset values immediately.
- Moves sent in DONE → ignored: no `move_err`, board unchanged.
